// File: rtl/matrix_vector_mac_seq.sv
// Sequential DIM x DIM signed fixed-point matrix * vector unit, one shared MAC per cycle.
// Optional macro MATRIX_VECTOR_MAC_SATURATE_EN selects saturating product/accumulate instead of wrap.
module matrix_vector_mac_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int DIM   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DIM*DIM*WIDTH-1:0]   i_matrix,
    input  logic [DIM*WIDTH-1:0]       i_vector,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DIM*WIDTH-1:0]       o_vector
);

    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    generate
        if (FRAC < 0 || FRAC >= WIDTH || DIM < 1) begin : g_bad_params
            $error("matrix_vector_mac_seq: illegal WIDTH/FRAC/DIM combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        r_q, r_d, c_q, c_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]        m_q [DIM][DIM];
    logic [WIDTH-1:0]        m_d [DIM][DIM];
    logic [WIDTH-1:0]        v_q [DIM];
    logic [WIDTH-1:0]        v_d [DIM];
    logic [WIDTH-1:0]        out_q [DIM];
    logic [WIDTH-1:0]        out_d [DIM];

    logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic signed [WIDTH-1:0]   term, acc_sum;

    // Operands are sign-extended to full product width so the multiply is exact.
    always_comb begin
        a_ext = {{WIDTH{m_q[r_q][c_q][WIDTH-1]}}, m_q[r_q][c_q]};
        b_ext = {{WIDTH{v_q[c_q][WIDTH-1]}}, v_q[c_q]};
        prod  = a_ext * b_ext;
    end

`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
    localparam logic signed [2*WIDTH-1:0] P_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] P_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0]   W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   W_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] prod_sh;
    logic [WIDTH:0]            sum_ext;

    always_comb begin
        prod_sh = prod >>> FRAC;
        if (prod_sh > P_MAX)      term = W_MAX;
        else if (prod_sh < P_MIN) term = W_MIN;
        else                      term = prod_sh[WIDTH-1:0];
        sum_ext = {acc_q[WIDTH-1], acc_q} + {term[WIDTH-1], term};
        if (sum_ext[WIDTH] != sum_ext[WIDTH-1]) acc_sum = sum_ext[WIDTH] ? W_MIN : W_MAX;
        else                                    acc_sum = sum_ext[WIDTH-1:0];
    end
`else
    always_comb begin
        term    = WIDTH'(prod >>> FRAC);
        acc_sum = acc_q + term;
    end
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        acc_d   = acc_q;
        m_d     = m_q;
        v_d     = v_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    for (int unsigned r = 0; r < DIM; r++) begin
                        v_d[r] = i_vector[r*WIDTH +: WIDTH];
                        for (int unsigned c = 0; c < DIM; c++)
                            m_d[r][c] = i_matrix[(r*DIM+c)*WIDTH +: WIDTH];
                    end
                    r_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (c_q == LAST) begin
                    out_d[r_q] = acc_sum;
                    acc_d      = '0;
                    c_d        = '0;
                    r_d        = r_q + IDX_W'(1);
                    if (r_q == LAST) begin
                        r_d     = '0;
                        state_d = DONE;
                    end
                end else begin
                    acc_d = acc_sum;
                    c_d   = c_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            r_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            m_q     <= '{default: '0};
            v_q     <= '{default: '0};
            out_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            v_q     <= v_d;
            out_q   <= out_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);

    generate
        for (genvar g = 0; g < DIM; g++) begin : g_out
            assign o_vector[g*WIDTH +: WIDTH] = out_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_matrix_vector_mac_seq.sv
// Self-checking bench for matrix_vector_mac_seq with an arithmetic reference model.
// Honours MATRIX_VECTOR_MAC_SATURATE_EN in the model to match the DUT build.
module tb_matrix_vector_mac_seq;

    localparam int W = 32;
    localparam int F = 16;
    localparam int D = 4;

    logic               clk = 1'b0;
    logic               rst, iv, ir, ov, ordy;
    logic [D*D*W-1:0]   mat;
    logic [D*W-1:0]     vec, res;

    int unsigned ncomp = 0;
    int unsigned nfail = 0;

    matrix_vector_mac_seq #(.WIDTH(W), .FRAC(F), .DIM(D)) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_valid  (iv),
        .o_ready  (ordy),
        .i_matrix (mat),
        .i_vector (vec),
        .o_valid  (ov),
        .i_ready  (ir),
        .o_vector (res)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [D*W-1:0] obs, input logic [D*W-1:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > 64'sd2147483647)  return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction

    function automatic logic [D*W-1:0] ref_mv(input logic [D*D*W-1:0] m, input logic [D*W-1:0] v);
        logic [D*W-1:0] y;
        longint acc, p;
        y = '0;
        for (int r = 0; r < D; r++) begin
            acc = 0;
            for (int c = 0; c < D; c++) begin
                p = longint'($signed(m[(r*D+c)*W +: W])) * longint'($signed(v[c*W +: W]));
                p = p >>> F;
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
                acc = clamp(acc + clamp(p));
`else
                acc = longint'(int'(acc + p));
`endif
            end
            y[r*W +: W] = acc[W-1:0];
        end
        return y;
    endfunction

    function automatic logic [31:0] fx(input int x);
        return x * 65536;
    endfunction

    function automatic logic [D*D*W-1:0] rand_mat();
        logic [D*D*W-1:0] m;
        for (int i = 0; i < D*D; i++) m[i*W +: W] = $urandom;
        return m;
    endfunction

    function automatic logic [D*W-1:0] rand_vec();
        logic [D*W-1:0] v;
        for (int i = 0; i < D; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    // Caller is positioned 1 time unit after a rising edge with the DUT in IDLE.
    task automatic run_job(input string tag, input logic [D*D*W-1:0] m, input logic [D*W-1:0] v,
                           input int stall, input bit noisy, output logic [D*W-1:0] got);
        logic [D*W-1:0] exp;
        int cyc;
        exp = ref_mv(m, v);
        check({tag, ".ready_before"}, {127'b0, ordy}, 1);
        mat = m; vec = v; iv = 1'b1; ir = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        cyc = 0;
        while (!ov && cyc < 200) begin
            if (noisy) begin
                iv  = 1'($urandom_range(0, 1));
                mat = rand_mat();
                vec = rand_vec();
            end
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".latency"}, (D*W)'(cyc), (D*W)'(D*D));
        check({tag, ".result"}, res, exp);
        check({tag, ".ready_done"}, {127'b0, ordy}, 0);
        got = res;
        for (int k = 0; k < stall; k++) begin
            if (noisy) iv = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check({tag, ".stall_vec"}, res, exp);
            check({tag, ".stall_valid"}, {127'b0, ov}, 1);
            check({tag, ".stall_ready"}, {127'b0, ordy}, 0);
        end
        iv = 1'b0; ir = 1'b1;
        @(posedge clk); #1;
        ir = 1'b0;
        check({tag, ".idle_valid"}, {127'b0, ov}, 0);
        check({tag, ".idle_ready"}, {127'b0, ordy}, 1);
    endtask

    initial begin
        logic [D*D*W-1:0] m;
        logic [D*W-1:0]   v, got, exp;

        rst = 1'b1; iv = 1'b0; ir = 1'b0; mat = '0; vec = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.valid", {127'b0, ov}, 0);
        check("reset.ready", {127'b0, ordy}, 1);
        check("reset.vector", res, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity
        m = '0;
        for (int i = 0; i < D; i++) m[(i*D+i)*W +: W] = 32'h0001_0000;
        v = {32'h0001_0000, 32'hFFFF_0000, 32'h0002_0000, 32'h0001_0000};
        run_job("identity", m, v, 0, 1'b0, got);
        check("identity.const", got, v);

        // Translation
        m = '0;
        for (int i = 0; i < D; i++) m[(i*D+i)*W +: W] = 32'h0001_0000;
        m[(0*D+3)*W +: W] = fx(5);
        m[(1*D+3)*W +: W] = fx(-3);
        m[(2*D+3)*W +: W] = fx(2);
        v = {fx(1), fx(3), fx(2), fx(1)};
        run_job("translate", m, v, 0, 1'b0, got);
        check("translate.const", got, {32'h0001_0000, 32'h0005_0000, 32'hFFFF_0000, 32'h0006_0000});

        // Rounding toward minus infinity
        m = '0; v = '0;
        m[0 +: W] = 32'hFFFF_8000;
        v[0 +: W] = 32'h0000_0001;
        run_job("round", m, v, 0, 1'b0, got);
        check("round.const", got, {96'b0, 32'hFFFF_FFFF});

        // Overflow on accumulate
        m = '0; v = '0;
        m[(0*D+0)*W +: W] = 32'h7FFF_0000;
        m[(0*D+1)*W +: W] = 32'h7FFF_0000;
        v[0 +: W] = 32'h0001_0000;
        v[W +: W] = 32'h0001_0000;
        run_job("overflow", m, v, 0, 1'b0, got);
`ifdef MATRIX_VECTOR_MAC_SATURATE_EN
        exp = {96'b0, 32'h7FFF_FFFF};
`else
        exp = {96'b0, 32'hFFFE_0000};
`endif
        check("overflow.const", got, exp);

        // Backpressure with noisy inputs during RUN and DONE
        run_job("backpressure", rand_mat(), rand_vec(), 10, 1'b1, got);

        // Asynchronous reset in the middle of RUN
        mat = rand_mat(); vec = rand_vec(); iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset.valid", {127'b0, ov}, 0);
        check("midreset.ready", {127'b0, ordy}, 1);
        check("midreset.vector", res, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_job("after_reset", rand_mat(), rand_vec(), 1, 1'b0, got);

        // Random jobs
        for (int j = 0; j < 6; j++)
            run_job("random", rand_mat(), rand_vec(), $urandom_range(0, 3), 1'(j % 2), got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
